dekatron_pulse_decoder: RTL and testbench
=========================================

// Module: dekatron_pulse_decoder
// PURPOSE
//  Receive end of the dekatron guide-pulse interface. Samples PulseRight_n/PulseLeft_n from a
//  pulse sender (or a real tube driver) and decodes each complete two-phase sequence into a
//  forward/reverse step. Tracks the glowing main cathode as a one-hot digit with carry/borrow.
//  Flags illegal or stalled sequences. Sits beside each counter tube as its digital shadow/readback.
// PARAMETERS
//  SYNC_STAGES    2    flops per input line in the synchronizer (min 2)
//  TIMEOUT_CYCLES 255  max cycles in a non-idle phase before Fault; 0 = timeout disabled
// PORTS
//  Clk          in   1   single clock; all logic on posedge
//  Rst          in   1   reset, synchronous, active-high
//  PulseRight_n in   1   guide-right pulse, active low, asynchronous to Clk
//  PulseLeft_n  in   1   guide-left pulse, active low, asynchronous to Clk
//  Set          in   1   load Position from In (one cycle)
//  In           in   10  one-hot digit to load
//  FaultClr     in   1   clears sticky Fault
//  Out          out  10  one-hot glowing cathode, bit0 = digit 0
//  StepFwd      out  1   1-cycle pulse: forward step decoded
//  StepRev      out  1   1-cycle pulse: reverse step decoded
//  Carry        out  1   1-cycle pulse with StepFwd when 9->0
//  Borrow       out  1   1-cycle pulse with StepRev when 0->9
//  Abort        out  1   1-cycle pulse: sequence abandoned (glow fell back, no step)
//  Fault        out  1   sticky: illegal code, bad Set value or timeout
//  Idle         out  1   FSM in IDLE (both lines high, no sequence pending)
// BEHAVIOUR
//  Reset: Out=10'b0000000001, Fault=0, Idle=1, all pulse outputs 0, FSM=IDLE, sync flops =1.
//  Sampled code P={L_n,R_n}: NONE=11, RIGHT=10, LEFT=01, FAIL=00 (after synchronizer).
//  FSM: IDLE -RIGHT-> FWD1 -LEFT-> FWD2 -NONE-> IDLE (+StepFwd);
//       IDLE -LEFT-> REV1 -RIGHT-> REV2 -NONE-> IDLE (+StepRev).
//  FWD1/REV1 -NONE-> IDLE with Abort, Out unchanged. FWD2-RIGHT->FWD1, REV2-LEFT->REV1 (fall back).
//  Same code held = stay. FAIL in any state -> Fault=1, state WAIT; WAIT -NONE-> IDLE, no step.
//  Latency: StepFwd/StepRev, Carry/Borrow and new Out all valid the cycle after the synchronized
//   code returns to NONE, i.e. SYNC_STAGES+1 Clk edges after the raw line rises.
//  Out rotates left on StepFwd (bit9->bit0, Carry=1), right on StepRev (bit0->bit9, Borrow=1).
//  Timeout: counter resets on every state change; reaching TIMEOUT_CYCLES in FWD*/REV* -> Fault, WAIT.
//  Set: highest priority after Rst. One-hot In -> Out<=In; non-one-hot -> Out kept, Fault=1.
//   Set also forces FSM to WAIT (mid-sequence pulses discarded); step/Carry/Borrow suppressed that cycle.
//  FaultClr clears Fault next cycle; a new fault in the same cycle wins (Fault stays 1).
//  Idle=1 only in IDLE; Rst mid-sequence discards the sequence with no pulses.
// CONFIGURATION
//  DEKATRON_DECODER_BCD_EN defined: adds output Bcd[3:0], registered binary value of Out,
//   updated same cycle as Out, reset 4'd0; Out not one-hot (never in normal operation) -> 4'hF.
//  Not defined: Bcd port and encoder absent; all other behaviour identical.
// STRUCTURE
//  dekatron_pkg: pulse code constants PULSE_NONE/RIGHT/LEFT/FAIL, FSM state encoding
//   (IDLE, FWD1, FWD2, REV1, REV2, WAIT), DIGITS=10.
//  Sub-module dekatron_sync: SYNC_STAGES-deep, reset-to-1 synchronizer, one instance per line.
// TESTING
//  Forward x12 from reset (11->10->01->11 each, 4 clk/phase) -> 12 StepFwd, 1 Carry, Out=0000000100.
//  Reverse x1 from reset (11->01->10->11) -> StepRev+Borrow, Out=1000000000.
//  11->10->11 -> Abort 1 cycle, no step, Out unchanged; 11->10->01->10->01->11 -> single StepFwd.
//  Drive 00 mid-sequence -> Fault=1, no step until 11; FaultClr -> Fault=0; next sequence steps.
//  Hold 10 for TIMEOUT_CYCLES+SYNC_STAGES+2 clk -> Fault=1; Set In=0000100000 during FWD2 -> Out=that, no step.
//  Set In=0000000011 -> Fault=1, Out unchanged; with BCD_EN after 7 forward steps Bcd=4'd7.

Source files
------------

// File: rtl/dekatron_pkg.sv
// Shared constants for the dekatron guide-pulse decoder: pulse codes, FSM encoding, digit helpers.
package dekatron_pkg;

   localparam int unsigned DIGITS = 10;

   // Sampled code is {L_n, R_n} after synchronisation.
   localparam logic [1:0] PULSE_NONE  = 2'b11;
   localparam logic [1:0] PULSE_RIGHT = 2'b10;
   localparam logic [1:0] PULSE_LEFT  = 2'b01;
   localparam logic [1:0] PULSE_FAIL  = 2'b00;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FWD1 = 3'd1;
   localparam logic [2:0] ST_FWD2 = 3'd2;
   localparam logic [2:0] ST_REV1 = 3'd3;
   localparam logic [2:0] ST_REV2 = 3'd4;
   localparam logic [2:0] ST_WAIT = 3'd5;

   function automatic logic is_onehot(input logic [DIGITS-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < DIGITS; i++) n += 32'(v[i]);
      return n == 1;
   endfunction

   function automatic logic [3:0] onehot_to_bin(input logic [DIGITS-1:0] v);
      logic [3:0] b;
      b = 4'hF;
      if (is_onehot(v))
         for (int unsigned i = 0; i < DIGITS; i++)
            if (v[i]) b = 4'(i);
      return b;
   endfunction

endpackage

// File: rtl/dekatron_pulse_decoder_if.sv
// Pulse/control/readback bundle between a guide-pulse source (master) and the decoder (slave).
// Bcd is present only when DEKATRON_DECODER_BCD_EN is defined.
interface dekatron_pulse_decoder_if;
   import dekatron_pkg::*;

   logic              PulseRight_n;
   logic              PulseLeft_n;
   logic              Set;
   logic [DIGITS-1:0] In;
   logic              FaultClr;
   logic [DIGITS-1:0] Out;
   logic              StepFwd;
   logic              StepRev;
   logic              Carry;
   logic              Borrow;
   logic              Abort;
   logic              Fault;
   logic              Idle;
`ifdef DEKATRON_DECODER_BCD_EN
   logic [3:0]        Bcd;
`endif

   modport master (
      output PulseRight_n, PulseLeft_n, Set, In, FaultClr,
      input  Out, StepFwd, StepRev, Carry, Borrow, Abort, Fault, Idle
`ifdef DEKATRON_DECODER_BCD_EN
      , input Bcd
`endif
   );

   modport slave (
      input  PulseRight_n, PulseLeft_n, Set, In, FaultClr,
      output Out, StepFwd, StepRev, Carry, Borrow, Abort, Fault, Idle
`ifdef DEKATRON_DECODER_BCD_EN
      , output Bcd
`endif
   );

endinterface

// File: rtl/dekatron_sync.sv
// Multi-flop synchronizer for one asynchronous active-low pulse line; resets to the idle level (1).
module dekatron_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Async_i,
   output logic Sync_o
);

   logic [STAGES-1:0] sync_q, sync_d;

   always_comb sync_d = {sync_q[STAGES-2:0], Async_i};

   always_ff @(posedge Clk) begin
      if (Rst) sync_q <= '1;
      else     sync_q <= sync_d;
   end

   assign Sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/dekatron_pulse_decoder.sv
// Decodes two-phase dekatron guide pulses into steps and tracks the glowing cathode one-hot.
// Optional DEKATRON_DECODER_BCD_EN adds a registered binary readback (Bcd).
module dekatron_pulse_decoder
   import dekatron_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     Clk,
   input  logic                     Rst,
   dekatron_pulse_decoder_if.slave  bus
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic              r_sync, l_sync;
   logic [1:0]        code;
   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIGITS-1:0] out_q, out_d;
   logic              fault_q, fault_d;
   logic              step_fwd_q, step_fwd_d, step_rev_q, step_rev_d;
   logic              carry_q, carry_d, borrow_q, borrow_d, abort_q, abort_d;
   logic              fault_set, in_seq, timeout;

   dekatron_sync #(.STAGES(SYNC_STAGES)) u_sync_right (
      .Clk(Clk), .Rst(Rst), .Async_i(bus.PulseRight_n), .Sync_o(r_sync)
   );

   dekatron_sync #(.STAGES(SYNC_STAGES)) u_sync_left (
      .Clk(Clk), .Rst(Rst), .Async_i(bus.PulseLeft_n), .Sync_o(l_sync)
   );

   assign code = {l_sync, r_sync};

   always_comb begin
      state_d    = state_q;
      step_fwd_d = 1'b0;
      step_rev_d = 1'b0;
      abort_d    = 1'b0;
      fault_set  = 1'b0;
      in_seq     = state_q inside {ST_FWD1, ST_FWD2, ST_REV1, ST_REV2};
      timeout    = (TIMEOUT_CYCLES != 0) && in_seq &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      case (state_q)
         ST_IDLE: begin
            if (code == PULSE_RIGHT)     state_d = ST_FWD1;
            else if (code == PULSE_LEFT) state_d = ST_REV1;
         end
         ST_FWD1: begin
            if (code == PULSE_LEFT) state_d = ST_FWD2;
            else if (code == PULSE_NONE) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end
         end
         ST_FWD2: begin
            if (code == PULSE_RIGHT) state_d = ST_FWD1;
            else if (code == PULSE_NONE) begin
               state_d    = ST_IDLE;
               step_fwd_d = 1'b1;
            end
         end
         ST_REV1: begin
            if (code == PULSE_RIGHT) state_d = ST_REV2;
            else if (code == PULSE_NONE) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end
         end
         ST_REV2: begin
            if (code == PULSE_LEFT) state_d = ST_REV1;
            else if (code == PULSE_NONE) begin
               state_d    = ST_IDLE;
               step_rev_d = 1'b1;
            end
         end
         ST_WAIT: if (code == PULSE_NONE) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A legal phase change in the same cycle restarts the stall timer rather than faulting.
      if (code == PULSE_FAIL || (timeout && state_d == state_q)) begin
         state_d    = ST_WAIT;
         fault_set  = 1'b1;
         step_fwd_d = 1'b0;
         step_rev_d = 1'b0;
         abort_d    = 1'b0;
      end

      if (bus.Set) begin
         state_d    = ST_WAIT;
         step_fwd_d = 1'b0;
         step_rev_d = 1'b0;
         abort_d    = 1'b0;
         fault_set  = !is_onehot(bus.In);
      end

      out_d = out_q;
      if (bus.Set && is_onehot(bus.In)) out_d = bus.In;
      else if (step_fwd_d)              out_d = {out_q[DIGITS-2:0], out_q[DIGITS-1]};
      else if (step_rev_d)              out_d = {out_q[0], out_q[DIGITS-1:1]};

      carry_d  = step_fwd_d & out_q[DIGITS-1];
      borrow_d = step_rev_d & out_q[0];
      fault_d  = (fault_q & ~bus.FaultClr) | fault_set;
      cnt_d    = (in_seq && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         out_q      <= DIGITS'(1);
         fault_q    <= 1'b0;
         step_fwd_q <= 1'b0;
         step_rev_q <= 1'b0;
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         fault_q    <= fault_d;
         step_fwd_q <= step_fwd_d;
         step_rev_q <= step_rev_d;
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         abort_q    <= abort_d;
      end
   end

`ifdef DEKATRON_DECODER_BCD_EN
   logic [3:0] bcd_q;

   always_ff @(posedge Clk) begin
      if (Rst) bcd_q <= 4'd0;
      else     bcd_q <= onehot_to_bin(out_d);
   end

   assign bus.Bcd = bcd_q;
`endif

   assign bus.Out     = out_q;
   assign bus.StepFwd = step_fwd_q;
   assign bus.StepRev = step_rev_q;
   assign bus.Carry   = carry_q;
   assign bus.Borrow  = borrow_q;
   assign bus.Abort   = abort_q;
   assign bus.Fault   = fault_q;
   assign bus.Idle    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_dekatron_pulse_decoder.sv
// Self-checking bench for dekatron_pulse_decoder: directed scenarios plus random pulse sequences
// against a digit-counter reference model.
module tb_dekatron_pulse_decoder;
   import dekatron_pkg::*;

   localparam int unsigned SYNC = 2;
   localparam int unsigned TMO  = 255;

   logic Clk = 1'b0;
   logic Rst;
   int   errors = 0;
   int   checks = 0;

   // Reference model: digit index of the glowing cathode plus running pulse totals.
   int pos;
   int n_fwd = 0, n_rev = 0, n_carry = 0, n_borrow = 0, n_abort = 0;
   int s_fwd, s_rev, s_carry, s_borrow, s_abort;
   logic [DIGITS-1:0] exp_out;

   dekatron_pulse_decoder_if bus();

   dekatron_pulse_decoder #(
      .SYNC_STAGES(SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      n_fwd    += int'(bus.StepFwd);
      n_rev    += int'(bus.StepRev);
      n_carry  += int'(bus.Carry);
      n_borrow += int'(bus.Borrow);
      n_abort  += int'(bus.Abort);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] c, input int unsigned n);
      bus.PulseLeft_n  = c[1];
      bus.PulseRight_n = c[0];
      tick(n);
   endtask

   task automatic snap();
      s_fwd = n_fwd; s_rev = n_rev; s_carry = n_carry; s_borrow = n_borrow; s_abort = n_abort;
   endtask

   task automatic settle();
      drive(PULSE_NONE, SYNC + 3);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      tick(2);
      Rst = 1'b0;
      pos = 0;
   endtask

   task automatic test_reset();
      Rst = 1'b1; bus.Set = 1'b0; bus.In = '0; bus.FaultClr = 1'b0;
      bus.PulseLeft_n = 1'b1; bus.PulseRight_n = 1'b1;
      tick(3);
      checks++;
      if (bus.Out !== 10'b0000000001) begin errors++; $display("FAIL reset_out: got %b expected %b", bus.Out, 10'b0000000001); end
      checks++;
      if ({bus.Fault, bus.Idle} !== 2'b01) begin errors++; $display("FAIL reset_fault_idle: got %b expected 01", {bus.Fault, bus.Idle}); end
      checks++;
      if ({bus.StepFwd, bus.StepRev, bus.Carry, bus.Borrow, bus.Abort} !== 5'b0) begin
         errors++; $display("FAIL reset_pulses: got %b expected 00000", {bus.StepFwd, bus.StepRev, bus.Carry, bus.Borrow, bus.Abort});
      end
      Rst = 1'b0;
      pos = 0;
      // Reset arriving mid-sequence must discard it without any pulse.
      snap();
      drive(PULSE_RIGHT, 4);
      drive(PULSE_LEFT, 4);
      Rst = 1'b1;
      drive(PULSE_NONE, 2);
      Rst = 1'b0;
      settle();
      checks++;
      if ((n_fwd - s_fwd) + (n_abort - s_abort) != 0 || bus.Out !== 10'b0000000001 || bus.Idle !== 1'b1) begin
         errors++; $display("FAIL reset_midseq: got steps=%0d aborts=%0d out=%b idle=%b expected 0 0 0000000001 1",
                            n_fwd - s_fwd, n_abort - s_abort, bus.Out, bus.Idle);
      end
   endtask

   task automatic test_forward_x12();
      snap();
      for (int i = 0; i < 12; i++) begin
         drive(PULSE_RIGHT, 4); drive(PULSE_LEFT, 4); drive(PULSE_NONE, 4);
      end
      settle();
      pos = (pos + 12) % 10;
      checks++;
      if (n_fwd - s_fwd != 12 || n_carry - s_carry != 1) begin
         errors++; $display("FAIL fwd12_counts: got fwd=%0d carry=%0d expected 12 1", n_fwd - s_fwd, n_carry - s_carry);
      end
      checks++;
      if (bus.Out !== 10'b0000000100) begin errors++; $display("FAIL fwd12_out: got %b expected 0000000100", bus.Out); end
   endtask

   task automatic test_reverse();
      do_reset();
      snap();
      drive(PULSE_LEFT, 4); drive(PULSE_RIGHT, 4); drive(PULSE_NONE, 4);
      settle();
      pos = 9;
      checks++;
      if (n_rev - s_rev != 1 || n_borrow - s_borrow != 1 || n_fwd - s_fwd != 0) begin
         errors++; $display("FAIL rev_counts: got rev=%0d borrow=%0d fwd=%0d expected 1 1 0", n_rev - s_rev, n_borrow - s_borrow, n_fwd - s_fwd);
      end
      checks++;
      if (bus.Out !== 10'b1000000000) begin errors++; $display("FAIL rev_out: got %b expected 1000000000", bus.Out); end
   endtask

   task automatic test_latency();
      // Starts at digit 9, so this step also carries.
      drive(PULSE_RIGHT, 4);
      drive(PULSE_LEFT, 4);
      bus.PulseLeft_n = 1'b1; bus.PulseRight_n = 1'b1;
      tick(SYNC);
      checks++;
      if (bus.StepFwd !== 1'b0 || bus.Out !== 10'b1000000000) begin
         errors++; $display("FAIL latency_early: got step=%b out=%b expected 0 1000000000", bus.StepFwd, bus.Out);
      end
      tick(1);
      checks++;
      if ({bus.StepFwd, bus.Carry} !== 2'b11 || bus.Out !== 10'b0000000001) begin
         errors++; $display("FAIL latency_edge: got step,carry=%b out=%b expected 11 0000000001", {bus.StepFwd, bus.Carry}, bus.Out);
      end
      tick(1);
      checks++;
      if ({bus.StepFwd, bus.Carry} !== 2'b00) begin errors++; $display("FAIL latency_width: got %b expected 00", {bus.StepFwd, bus.Carry}); end
      pos = 0;
   endtask

   task automatic test_abort_fallback();
      snap();
      drive(PULSE_RIGHT, 4); settle();
      drive(PULSE_LEFT, 4);  settle();
      checks++;
      if (n_abort - s_abort != 2 || n_fwd - s_fwd + n_rev - s_rev != 0 || bus.Out !== 10'b0000000001) begin
         errors++; $display("FAIL abort: got aborts=%0d steps=%0d out=%b expected 2 0 0000000001",
                            n_abort - s_abort, n_fwd - s_fwd + n_rev - s_rev, bus.Out);
      end
      snap();
      drive(PULSE_RIGHT, 4); drive(PULSE_LEFT, 4); drive(PULSE_RIGHT, 4); drive(PULSE_LEFT, 4);
      settle();
      pos = 1;
      checks++;
      if (n_fwd - s_fwd != 1 || n_abort - s_abort != 0 || bus.Out !== 10'b0000000010) begin
         errors++; $display("FAIL fallback: got fwd=%0d aborts=%0d out=%b expected 1 0 0000000010", n_fwd - s_fwd, n_abort - s_abort, bus.Out);
      end
   endtask

   task automatic test_fault();
      snap();
      drive(PULSE_RIGHT, 4);
      drive(PULSE_FAIL, 4);
      checks++;
      if ({bus.Fault, bus.Idle} !== 2'b10) begin errors++; $display("FAIL fault_set: got fault,idle=%b expected 10", {bus.Fault, bus.Idle}); end
      bus.FaultClr = 1'b1;
      drive(PULSE_FAIL, 2);
      bus.FaultClr = 1'b0;
      checks++;
      if (bus.Fault !== 1'b1) begin errors++; $display("FAIL fault_clr_collision: got %b expected 1", bus.Fault); end
      drive(PULSE_LEFT, 4);
      settle();
      checks++;
      if (n_fwd - s_fwd + n_rev - s_rev != 0 || bus.Fault !== 1'b1 || bus.Idle !== 1'b1 || bus.Out !== 10'b0000000010) begin
         errors++; $display("FAIL fault_nostep: got steps=%0d fault=%b idle=%b out=%b expected 0 1 1 0000000010",
                            n_fwd - s_fwd + n_rev - s_rev, bus.Fault, bus.Idle, bus.Out);
      end
      bus.FaultClr = 1'b1;
      tick(1);
      bus.FaultClr = 1'b0;
      checks++;
      if (bus.Fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", bus.Fault); end
      snap();
      drive(PULSE_RIGHT, 3); drive(PULSE_LEFT, 3); settle();
      pos = 2;
      checks++;
      if (n_fwd - s_fwd != 1 || bus.Out !== 10'b0000000100) begin
         errors++; $display("FAIL fault_recover: got fwd=%0d out=%b expected 1 0000000100", n_fwd - s_fwd, bus.Out);
      end
   endtask

   task automatic test_timeout_set();
      snap();
      drive(PULSE_RIGHT, TMO / 2);
      checks++;
      if (bus.Fault !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", bus.Fault); end
      drive(PULSE_RIGHT, TMO + SYNC + 2 - TMO / 2);
      checks++;
      if ({bus.Fault, bus.Idle} !== 2'b10) begin errors++; $display("FAIL timeout_fault: got fault,idle=%b expected 10", {bus.Fault, bus.Idle}); end
      settle();
      checks++;
      if (n_fwd - s_fwd + n_abort - s_abort != 0 || bus.Idle !== 1'b1) begin
         errors++; $display("FAIL timeout_recover: got steps+aborts=%0d idle=%b expected 0 1", n_fwd - s_fwd + n_abort - s_abort, bus.Idle);
      end
      bus.FaultClr = 1'b1; tick(1); bus.FaultClr = 1'b0;
      snap();
      drive(PULSE_RIGHT, 4);
      drive(PULSE_LEFT, 4);
      bus.Set = 1'b1; bus.In = 10'b0000100000;
      tick(1);
      bus.Set = 1'b0; bus.In = '0;
      drive(PULSE_LEFT, 2);
      settle();
      pos = 5;
      checks++;
      if (bus.Out !== 10'b0000100000 || n_fwd - s_fwd != 0 || bus.Fault !== 1'b0) begin
         errors++; $display("FAIL set_fwd2: got out=%b fwd=%0d fault=%b expected 0000100000 0 0", bus.Out, n_fwd - s_fwd, bus.Fault);
      end
   endtask

   task automatic test_bad_set();
      bus.Set = 1'b1; bus.In = 10'b0000000011;
      tick(1);
      bus.Set = 1'b0; bus.In = '0;
      checks++;
      if (bus.Fault !== 1'b1 || bus.Out !== 10'b0000100000) begin
         errors++; $display("FAIL bad_set_two: got fault=%b out=%b expected 1 0000100000", bus.Fault, bus.Out);
      end
      bus.FaultClr = 1'b1; tick(1); bus.FaultClr = 1'b0;
      bus.Set = 1'b1; bus.In = '0;
      tick(1);
      bus.Set = 1'b0;
      checks++;
      if (bus.Fault !== 1'b1 || bus.Out !== 10'b0000100000) begin
         errors++; $display("FAIL bad_set_zero: got fault=%b out=%b expected 1 0000100000", bus.Fault, bus.Out);
      end
      bus.FaultClr = 1'b1; tick(1); bus.FaultClr = 1'b0;
      settle();
   endtask

   task automatic test_back_to_back();
      snap();
      for (int i = 0; i < 5; i++) begin
         drive(PULSE_RIGHT, 1); drive(PULSE_LEFT, 1); drive(PULSE_NONE, 1);
      end
      settle();
      pos = (pos + 5) % 10;
      exp_out = DIGITS'(1) << pos;
      checks++;
      if (n_fwd - s_fwd != 5 || bus.Out !== exp_out) begin
         errors++; $display("FAIL back_to_back: got fwd=%0d out=%b expected 5 %b", n_fwd - s_fwd, bus.Out, exp_out);
      end
   endtask

   task automatic test_random();
      int e_fwd, e_rev, e_carry, e_borrow, e_abort;
      int unsigned kind, k, d;
      e_fwd = 0; e_rev = 0; e_carry = 0; e_borrow = 0; e_abort = 0;
      snap();
      for (int it = 0; it < 60; it++) begin
         kind = $urandom_range(0, 5);
         case (kind)
            0: begin
               drive(PULSE_RIGHT, $urandom_range(1, 5)); drive(PULSE_LEFT, $urandom_range(1, 5));
               if (pos == 9) e_carry++;
               pos = (pos + 1) % 10; e_fwd++;
            end
            1: begin
               drive(PULSE_LEFT, $urandom_range(1, 5)); drive(PULSE_RIGHT, $urandom_range(1, 5));
               if (pos == 0) e_borrow++;
               pos = (pos + 9) % 10; e_rev++;
            end
            2: begin drive(PULSE_RIGHT, $urandom_range(1, 5)); e_abort++; end
            3: begin drive(PULSE_LEFT, $urandom_range(1, 5));  e_abort++; end
            4: begin
               k = $urandom_range(1, 3);
               drive(PULSE_RIGHT, $urandom_range(1, 5)); drive(PULSE_LEFT, $urandom_range(1, 5));
               for (int unsigned j = 0; j < k; j++) begin
                  drive(PULSE_RIGHT, $urandom_range(1, 5)); drive(PULSE_LEFT, $urandom_range(1, 5));
               end
               if (pos == 9) e_carry++;
               pos = (pos + 1) % 10; e_fwd++;
            end
            default: begin
               d = $urandom_range(0, 9);
               bus.Set = 1'b1; bus.In = DIGITS'(1) << d;
               tick(1);
               bus.Set = 1'b0; bus.In = '0;
               pos = int'(d);
            end
         endcase
         drive(PULSE_NONE, $urandom_range(SYNC + 3, SYNC + 6));
         exp_out = DIGITS'(1) << pos;
         checks++;
         if (bus.Out !== exp_out || bus.Fault !== 1'b0) begin
            errors++; $display("FAIL random_out it=%0d kind=%0d: got out=%b fault=%b expected %b 0", it, kind, bus.Out, bus.Fault, exp_out);
         end
`ifdef DEKATRON_DECODER_BCD_EN
         checks++;
         if (bus.Bcd !== 4'(pos)) begin errors++; $display("FAIL random_bcd it=%0d: got %0d expected %0d", it, bus.Bcd, pos); end
`endif
      end
      checks++;
      if (n_fwd - s_fwd != e_fwd || n_rev - s_rev != e_rev || n_carry - s_carry != e_carry ||
          n_borrow - s_borrow != e_borrow || n_abort - s_abort != e_abort) begin
         errors++; $display("FAIL random_counts: got fwd=%0d rev=%0d carry=%0d borrow=%0d abort=%0d expected %0d %0d %0d %0d %0d",
                            n_fwd - s_fwd, n_rev - s_rev, n_carry - s_carry, n_borrow - s_borrow, n_abort - s_abort,
                            e_fwd, e_rev, e_carry, e_borrow, e_abort);
      end
   endtask

`ifdef DEKATRON_DECODER_BCD_EN
   task automatic test_bcd();
      checks++;
      do_reset();
      if (bus.Bcd !== 4'd0) begin errors++; $display("FAIL bcd_reset: got %0d expected 0", bus.Bcd); end
      for (int i = 0; i < 7; i++) begin
         drive(PULSE_RIGHT, 4); drive(PULSE_LEFT, 4); drive(PULSE_NONE, 4);
      end
      settle();
      pos = 7;
      checks++;
      if (bus.Bcd !== 4'd7) begin errors++; $display("FAIL bcd_seven: got %0d expected 7", bus.Bcd); end
   endtask
`endif

   initial begin
      test_reset();
      test_forward_x12();
      test_reverse();
      test_latency();
      test_abort_fallback();
      test_fault();
      test_timeout_set();
      test_bad_set();
      test_back_to_back();
      test_random();
`ifdef DEKATRON_DECODER_BCD_EN
      test_bcd();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
